// File: rtl/intc_pkg.sv
// intc_pkg: shared constants for the memory-mapped interrupt controller
package intc_pkg;
  localparam int N_SRC = 6;
  localparam int CW = 3;
  localparam logic [4:0] OFF_PEND  = 5'h00;
  localparam logic [4:0] OFF_MASK  = 5'h04;
  localparam logic [4:0] OFF_MODE  = 5'h08;
  localparam logic [4:0] OFF_CLAIM = 5'h0C;
  localparam logic [4:0] OFF_EOI   = 5'h10;
  localparam logic [4:0] OFF_INSVC = 5'h14;
endpackage

// File: rtl/intc_prio.sv
// intc_prio: combinational priority encoder, highest set index wins
// ports: vec_i request vector; valid_o any bit set; idx_o index of highest set bit
module intc_prio
  import intc_pkg::*;
(
  input  logic [N_SRC-1:0] vec_i,
  output logic             valid_o,
  output logic [CW-1:0]    idx_o
);
  always_comb begin
    valid_o = |vec_i;
    idx_o = '0;
    for (int i = 0; i < N_SRC; i++) idx_o = vec_i[i] ? CW'(i) : idx_o;
  end
endmodule

// File: rtl/intc_mmio.sv
// intc_mmio: memory-mapped interrupt controller driving the core INT lines
// ports: clk/rst sync active-high; irq_src async requests; addr/we/re/wd core bus;
//        rd combinational read data; hit window decode; INT registered requests
module intc_mmio
  import intc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_FF00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [31:0]      addr,
  input  logic             we,
  input  logic             re,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  output logic             hit,
  output logic [N_SRC-1:0] INT
);
  logic [N_SRC-1:0] s1_q, s2_q, prev_q, pend_q, pend_d, mask_q, mode_q, ins_q, ins_d, int_q;
  logic [N_SRC-1:0] above, elig, edge_det, w1c, claim_set, eoi_clr;
  logic [4:0] off;
  logic wr, rfx, ins_v, cl_v, eoi_ok;
  logic [CW-1:0] ins_idx, cl_idx;
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wd[31:CW]};
  assign hit = addr[31:5] == BASE_ADDR[31:5];
  assign off = {addr[4:2], 2'b00};
  assign wr = hit & we;
  assign rfx = hit & re & ~we;
  assign edge_det = s2_q & ~prev_q;
  intc_prio u_ins (.vec_i(ins_q), .valid_o(ins_v), .idx_o(ins_idx));
  intc_prio u_claim (.vec_i(elig), .valid_o(cl_v), .idx_o(cl_idx));
  // only sources strictly above the highest in-service index may interrupt
  always_comb begin
    above = '0;
    for (int i = 0; i < N_SRC; i++) above[i] = !ins_v || (i > int'(ins_idx));
  end
  assign elig = pend_q & mask_q & above;
  assign claim_set = (rfx && off == OFF_CLAIM && cl_v) ? N_SRC'(1) << cl_idx : '0;
  assign w1c = (wr && off == OFF_PEND) ? wd[N_SRC-1:0] : '0;
  assign eoi_ok = wr && off == OFF_EOI && wd[CW-1:0] != '0 && int'(wd[CW-1:0]) <= N_SRC;
  assign eoi_clr = eoi_ok ? N_SRC'(1) << (wd[CW-1:0] - CW'(1)) : '0;
  // edge bits: set beats clear; level bits simply track the synced input
  assign pend_d = (mode_q & ((pend_q & ~w1c & ~claim_set) | edge_det)) | (~mode_q & s2_q);
  assign ins_d = (ins_q & ~eoi_clr) | claim_set;
  always_comb begin
    rd = '0;
    if (hit)
      rd = off == OFF_PEND  ? 32'(pend_q) :
           off == OFF_MASK  ? 32'(mask_q) :
           off == OFF_MODE  ? 32'(mode_q) :
           off == OFF_CLAIM ? (cl_v ? 32'(cl_idx) + 32'd1 : 32'd0) :
           off == OFF_INSVC ? 32'(ins_q) : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      prev_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
      mode_q <= '0;
      ins_q <= '0;
      int_q <= '0;
    end else begin
      s1_q <= irq_src;
      s2_q <= s1_q;
      prev_q <= s2_q;
      pend_q <= pend_d;
      ins_q <= ins_d;
      int_q <= elig;
      if (wr && off == OFF_MASK) mask_q <= wd[N_SRC-1:0];
      if (wr && off == OFF_MODE) mode_q <= wd[N_SRC-1:0];
    end
  end
  assign INT = int_q;
endmodule

// File: tb/tb_intc_mmio.sv
// tb_intc_mmio: scoreboard bench for intc_mmio with directed vectors
module tb_intc_mmio;
  localparam logic [31:0] BASE = 32'h0000_FF00;
  localparam int K_RD = 0, K_INT = 1, K_HIT = 2;
  typedef struct {
    int kind;
    logic [31:0] exp;
    string name;
  } exp_t;
  logic clk, rst, we, re, hit, obs;
  logic [5:0] irq_src, int_o;
  logic [31:0] addr, wd, rd, act;
  exp_t sb[$];
  exp_t e;
  int checks = 0, errors = 0;
  intc_mmio dut (.clk(clk), .rst(rst), .irq_src(irq_src), .addr(addr), .we(we), .re(re),
                 .wd(wd), .rd(rd), .hit(hit), .INT(int_o));
  initial clk = 0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (obs) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: got no expectation, required one");
      end else begin
        e = sb.pop_front();
        act = e.kind == K_RD ? rd : e.kind == K_INT ? 32'(int_o) : 32'(hit);
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h required %h", e.name, act, e.exp);
        end
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_obs(input int kind, input logic [31:0] v, input string name);
    exp_t x;
    x.kind = kind;
    x.exp = v;
    x.name = name;
    sb.push_back(x);
    obs = 1;
    cyc();
    obs = 0;
  endtask
  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    addr = BASE + 32'(off);
    wd = d;
    we = 1;
    cyc();
    we = 0;
    addr = 0;
  endtask
  task automatic rd_chk(input logic [4:0] off, input logic [31:0] v, input string name);
    addr = BASE + 32'(off);
    re = 1;
    expect_obs(K_RD, v, name);
    re = 0;
    addr = 0;
  endtask
  task automatic hit_chk(input logic [31:0] a, input logic v, input string name);
    addr = a;
    expect_obs(K_HIT, 32'(v), name);
    addr = 0;
  endtask
  task automatic pulse(input logic [5:0] m);
    irq_src = irq_src | m;
    cyc();
    irq_src = irq_src & ~m;
    repeat (3) cyc();
  endtask
  initial begin
    rst = 1; irq_src = 0; addr = 0; we = 0; re = 0; wd = 0; obs = 0;
    repeat (3) cyc();
    rst = 0;
    rd_chk(5'h00, 0, "rst_pend");
    rd_chk(5'h04, 0, "rst_mask");
    rd_chk(5'h08, 0, "rst_mode");
    rd_chk(5'h0C, 0, "rst_claim");
    rd_chk(5'h10, 0, "rst_eoi");
    rd_chk(5'h14, 0, "rst_insvc");
    rd_chk(5'h18, 0, "unmapped");
    expect_obs(K_INT, 0, "rst_int");
    hit_chk(32'h0000_0100, 0, "miss");
    hit_chk(BASE + 32'h1C, 1, "hit_top");
    wr(5'h04, 32'h3F);
    wr(5'h08, 32'h3F);
    rd_chk(5'h04, 32'h3F, "mask_rb");
    rd_chk(5'h08, 32'h3F, "mode_rb");
    irq_src = 6'h04;
    cyc();
    irq_src = 0;
    cyc();
    cyc();
    expect_obs(K_INT, 0, "int_before_e3");
    expect_obs(K_INT, 32'h04, "int_at_e3");
    rd_chk(5'h0C, 3, "claim_src2");
    rd_chk(5'h00, 0, "pend_after_claim");
    rd_chk(5'h14, 32'h04, "insvc_after_claim");
    expect_obs(K_INT, 0, "int_after_claim");
    wr(5'h10, 3);
    rd_chk(5'h14, 0, "insvc_after_eoi3");
    pulse(6'h12);
    expect_obs(K_INT, 32'h12, "int_src14");
    rd_chk(5'h00, 32'h12, "pend_src14");
    rd_chk(5'h0C, 5, "claim_src4");
    rd_chk(5'h0C, 0, "claim_blocked");
    rd_chk(5'h00, 32'h02, "pend_src1_held");
    expect_obs(K_INT, 0, "int_blocked");
    wr(5'h10, 7);
    wr(5'h10, 0);
    rd_chk(5'h14, 32'h10, "eoi_bad_ignored");
    wr(5'h10, 5);
    rd_chk(5'h0C, 2, "claim_src1");
    wr(5'h10, 2);
    rd_chk(5'h14, 0, "insvc_clear");
    wr(5'h08, 32'h3E);
    irq_src = 6'h01;
    repeat (3) cyc();
    rd_chk(5'h00, 32'h01, "level_pend");
    wr(5'h00, 32'h01);
    rd_chk(5'h00, 32'h01, "level_w1c_noeffect");
    expect_obs(K_INT, 32'h01, "level_int");
    irq_src = 0;
    cyc();
    cyc();
    rd_chk(5'h00, 32'h01, "level_drop_e1");
    rd_chk(5'h00, 0, "level_drop_e2");
    wr(5'h08, 32'h3F);
    irq_src = 6'h08;
    cyc();
    cyc();
    wr(5'h00, 32'h08);
    rd_chk(5'h00, 32'h08, "edge_beats_w1c");
    wr(5'h00, 32'h08);
    rd_chk(5'h00, 0, "w1c_clears");
    irq_src = 0;
    repeat (3) cyc();
    pulse(6'h02);
    rd_chk(5'h0C, 2, "nest_claim1");
    pulse(6'h01);
    expect_obs(K_INT, 0, "nest_block");
    rd_chk(5'h00, 32'h01, "nest_pend0");
    pulse(6'h20);
    expect_obs(K_INT, 32'h20, "nest_preempt");
    addr = BASE + 32'h0C;
    we = 1;
    re = 1;
    wd = 0;
    cyc();
    we = 0;
    re = 0;
    addr = 0;
    rd_chk(5'h14, 32'h02, "we_re_no_claim");
    rd_chk(5'h0C, 6, "nest_claim5");
    rd_chk(5'h14, 32'h22, "nest_insvc");
    rst = 1;
    cyc();
    rst = 0;
    rd_chk(5'h14, 0, "midrst_insvc");
    rd_chk(5'h04, 0, "midrst_mask");
    expect_obs(K_INT, 0, "midrst_int");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
